// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared state type, output widths and counter sizing for the PLL lock supervisor
package pll_sup_pkg;
    typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAIL} pll_state_t;
    localparam int RETRY_W = 3;
    localparam int LOSS_W = 8;
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m);
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, async active-high reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q <= 1'b0;
        end else begin
            meta <= d;
            q <= meta;
        end
    end
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, waits for and debounces lock, then releases core reset
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 5000000,
    parameter int LOCK_STABLE_CYCLES = 65536,
    parameter int RELOCK_MAX = 7
) (
    input  logic refclk,
    input  logic rst,
    input  logic ext_reset_req,
    input  logic pll_locked,
    output logic pll_rst,
    output logic sys_reset,
    output logic pll_ready,
    output logic fail,
    output logic [RETRY_W-1:0] retry_count,
    output logic [LOSS_W-1:0] lock_loss_count
);
    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    if (RELOCK_MAX > 7 || PLL_RST_CYCLES < 2 || LOCK_TIMEOUT_CYCLES < 2 || LOCK_STABLE_CYCLES < 2) begin : g_bad_param
        $error("pll_lock_supervisor: illegal parameter value");
    end
    pll_state_t state, nxt;
    logic [CW-1:0] cnt;
    logic locked_s, inc_retry, loss;
    sync_2ff u_sync (.clk(refclk), .rst(rst), .d(pll_locked), .q(locked_s));
    always_comb begin
        nxt = state;
        inc_retry = 1'b0;
        loss = 1'b0;
        case (state)
            RESET_PLL: nxt = (cnt == CW'(PLL_RST_CYCLES - 1)) ? WAIT_LOCK : RESET_PLL;
            WAIT_LOCK: begin
                if (locked_s) nxt = STABILIZE;
                else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    nxt = (retry_count == RETRY_W'(RELOCK_MAX)) ? FAIL : RESET_PLL;
                    inc_retry = (retry_count != RETRY_W'(RELOCK_MAX));
                end
            end
            STABILIZE: nxt = !locked_s ? WAIT_LOCK : (cnt == CW'(LOCK_STABLE_CYCLES - 1)) ? RUN : STABILIZE;
            RUN: begin
                loss = !locked_s;
                nxt = loss ? RESET_PLL : RUN;
            end
            FAIL: nxt = FAIL;
            default: nxt = RESET_PLL;
        endcase
        // ext_reset_req overrides the transition but a coincident lock loss is still recorded
        if (ext_reset_req) nxt = RESET_PLL;
    end
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state <= RESET_PLL;
            cnt <= '0;
            retry_count <= '0;
            lock_loss_count <= '0;
            pll_rst <= 1'b1;
            sys_reset <= 1'b1;
            pll_ready <= 1'b0;
            fail <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= (ext_reset_req || nxt != state) ? '0 : cnt + CW'(1);
            retry_count <= (ext_reset_req || loss) ? '0 : retry_count + RETRY_W'(inc_retry);
            lock_loss_count <= (loss && lock_loss_count != '1) ? lock_loss_count + LOSS_W'(1) : lock_loss_count;
            pll_rst <= (nxt == RESET_PLL || nxt == FAIL);
            sys_reset <= (nxt != RUN);
            pll_ready <= (nxt == RUN);
            fail <= (nxt == FAIL);
        end
    end
endmodule
